// File: rtl/vu_pkg.sv
// vu_pkg: shared colour constants and active display size for the VU bar renderer.
package vu_pkg;
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t BLACK  = '{r: 3'b000, g: 3'b000, b: 2'b00};
    localparam rgb_t GREEN  = '{r: 3'b000, g: 3'b111, b: 2'b00};
    localparam rgb_t YELLOW = '{r: 3'b111, g: 3'b111, b: 2'b00};
    localparam rgb_t RED    = '{r: 3'b111, g: 3'b000, b: 2'b00};
    localparam rgb_t WHITE  = '{r: 3'b111, g: 3'b111, b: 2'b11};

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
endpackage

// File: rtl/vu_peak_hold.sv
// vu_peak_hold: one meter channel; shadow level, frame-latched level and decaying peak marker.
module vu_peak_hold #(
    parameter int LVL_W   = 6,
    parameter int HOLD_FR = 30,
    parameter int DECAY   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             wr,
    input  logic [LVL_W-1:0] wr_data,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] peak
);
    localparam int HW = $clog2(HOLD_FR + 2);

    logic [LVL_W-1:0] shadow, nxt, dec;
    logic [HW-1:0]    hold;

    // a write coinciding with frame_start is shown in the frame it starts
    assign nxt = wr ? wr_data : shadow;
    assign dec = peak >= LVL_W'(DECAY) ? peak - LVL_W'(DECAY) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            level  <= '0;
            peak   <= '0;
            hold   <= '0;
        end else begin
            if (wr)
                shadow <= wr_data;
            if (frame_start) begin
                level <= nxt;
                if (nxt >= peak) begin
                    peak <= nxt;
                    hold <= HW'(HOLD_FR);
                end else if (hold != '0)
                    hold <= hold - HW'(1);
                else
                    peak <= dec > nxt ? dec : nxt;
            end
        end
    end
endmodule

// File: rtl/vu_bar_pixelgen.sv
// vu_bar_pixelgen: renders NCH horizontal VU bars with zone colours and peak-hold markers.
module vu_bar_pixelgen #(
    parameter int NCH     = 2,
    parameter int LVL_W   = 6,
    parameter int HSH     = 3,
    parameter int BAND_H  = 240,
    parameter int GRN_END = 320,
    parameter int YEL_END = 480,
    parameter int HOLD_FR = 30,
    parameter int DECAY   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [9:0]       hc,
    input  logic [8:0]       vc,
    input  logic             frame_start,
    input  logic             lvl_valid,
    input  logic [2:0]       lvl_ch,
    input  logic [LVL_W-1:0] lvl_data,
    output logic [2:0]       RED,
    output logic [2:0]       GREEN,
    output logic [1:0]       BLUE
);
    import vu_pkg::*;

    logic [3:0]       band, band_n;
    logic [8:0]       line, line_n;
    logic             sync, sync_n;
    logic [LVL_W-1:0] lvl_a [NCH];
    logic [LVL_W-1:0] pk_a [NCH];
    logic [LVL_W-1:0] lvl, pk;
    logic [9:0]       col;
    rgb_t             zone, pix;

    // band position applies from the hc==0 pixel onward; nothing renders until the first frame top
    always_comb begin
        sync_n = sync | (hc == 10'd0 && vc == 9'd0);
        band_n = band;
        line_n = line;
        if (hc == 10'd0) begin
            if (vc == 9'd0) begin
                band_n = '0;
                line_n = '0;
            end else if (line == 9'(BAND_H - 1)) begin
                line_n = '0;
                band_n = &band ? band : band + 4'd1;
            end else
                line_n = line + 9'd1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            vu_peak_hold #(.LVL_W(LVL_W), .HOLD_FR(HOLD_FR), .DECAY(DECAY)) u_ph (
                .clk(clk),
                .rst(rst),
                .frame_start(frame_start),
                .wr(lvl_valid && lvl_ch == 3'(g)),
                .wr_data(lvl_data),
                .level(lvl_a[g]),
                .peak(pk_a[g])
            );
        end
    endgenerate

    always_comb begin
        lvl = '0;
        pk  = '0;
        for (int i = 0; i < NCH; i++)
            if (band_n == 4'(i)) begin
                lvl = lvl_a[i];
                pk  = pk_a[i];
            end
    end

    assign col  = hc >> HSH;
    assign zone = hc < 10'(GRN_END) ? vu_pkg::GREEN : hc < 10'(YEL_END) ? vu_pkg::YELLOW : vu_pkg::RED;
    assign pix  = (!en || !sync_n || band_n >= 4'(NCH) || hc >= 10'(H_ACT)) ? BLACK :
                  (pk != '0 && col == 10'(pk)) ? WHITE :
                  col < 10'(lvl) ? zone : BLACK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band <= '0;
            line <= '0;
            sync <= 1'b0;
            {RED, GREEN, BLUE} <= '0;
        end else begin
            band <= band_n;
            line <= line_n;
            sync <= sync_n;
            {RED, GREEN, BLUE} <= pix;
        end
    end
endmodule

// File: doc/vu_bar_pixelgen.md
VU_BAR_PIXELGEN -- requirements
Module: vu_bar_pixelgen

Interface
REQ-001 SHALL provide parameter NCH, default 2, number of meter channels (1..8).
REQ-002 SHALL provide parameter LVL_W, default 6, level width in bits.
REQ-003 SHALL provide parameter HSH, default 3, log2 of columns per level step (bar length = level << HSH).
REQ-004 SHALL provide parameter BAND_H, default 240, lines per channel band (NCH*BAND_H <= 480).
REQ-005 SHALL provide parameters GRN_END, default 320, and YEL_END, default 480, colour zone column limits.
REQ-006 SHALL provide parameters HOLD_FR, default 30, peak-hold frames, and DECAY, default 1, peak decay step per frame.
REQ-007 clk  in  1  pixel clock; one clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 en  in  1  display enable; 0 forces black.
REQ-010 hc  in  10  horizontal pixel counter, active 0..639.
REQ-011 vc  in  9  vertical line counter, active 0..479.
REQ-012 frame_start  in  1  single-cycle pulse, once per frame, during blanking.
REQ-013 lvl_valid  in  1  level write strobe.
REQ-014 lvl_ch  in  3  target channel of level write.
REQ-015 lvl_data  in  LVL_W  new level value.
REQ-016 RED, GREEN  out  3 each; BLUE  out  2; registered colour.

Function
REQ-017 lvl_valid with lvl_ch < NCH SHALL write lvl_data to that channel's shadow register; lvl_ch >= NCH SHALL be ignored.
REQ-018 On frame_start, every channel's displayed level SHALL load its shadow value; writes never change the displayed level mid-frame.
REQ-019 lvl_valid and frame_start in the same cycle SHALL display the newly written value for that channel.
REQ-020 Band tracking: on hc==0 with vc==0, band=0, line=0; on hc==0 otherwise, line increments; line==BAND_H-1 wraps line to 0 and increments band.
REQ-021 Lines with band >= NCH SHALL render black.
REQ-022 On frame_start per channel: if new level >= peak, peak=new level and hold=HOLD_FR; else if hold>0, hold decrements; else peak = max(peak-DECAY, new level), saturating, never below 0.
REQ-023 Pixel priority: en==0 or band>=NCH or hc>=640 -> 000/000/00; (hc>>HSH)==peak and peak!=0 -> white 111/111/11; (hc>>HSH)<level -> zone colour; else black.
REQ-024 Zone colour: hc<GRN_END green 000/111/00; hc<YEL_END yellow 111/111/00; otherwise red 111/000/00.
REQ-025 Colour outputs SHALL appear exactly 1 clk after the hc/vc/en they correspond to.
REQ-026 Level arithmetic SHALL be unsigned; peak and decay comparisons in LVL_W bits with no wrap.

Reset
REQ-027 Reset SHALL clear RED/GREEN/BLUE, all shadow, level, peak and hold registers, band and line to 0.
REQ-028 Reset asserted mid-frame SHALL black the output asynchronously; rendering resumes at the next vc==0, hc==0.

Structure
REQ-029 Colour constants (BLACK, GREEN, YELLOW, RED, WHITE) and 640/480 active sizes SHALL live in shared package vu_pkg.
REQ-030 Per-channel shadow/level/peak/hold logic SHALL be sub-module vu_peak_hold, instantiated NCH times.

Verification
REQ-031 Write ch0=20, frame_start; line 10, hc=100 -> green; hc=160 -> peak marker white; hc=168 -> black.
REQ-032 ch1=63 after frame_start, line 300: hc=300 green, hc=400 yellow, hc=500 red, hc=504 white.
REQ-033 Set ch0=40, then 0 for HOLD_FR+5 frames -> peak at 40 for 30 frames, then 39, 38, ... one per frame.
REQ-034 Write ch0 mid-frame at line 100 -> lines 101..239 unchanged until next frame_start.
REQ-035 lvl_ch=5 with NCH=2 -> no state change; en=0 -> all outputs 0 next cycle.
REQ-036 Assert rst at line 50 -> outputs 0 immediately; after release, next frame black until levels rewritten.
